// File: rtl/seq_approx_mult.sv
// ---------------------------------------------------------------------------
// seq_approx_mult
//
// Sequential unsigned shift-add multiplier that adds one partial product per
// clock. It can optionally truncate the result: in approximate mode, every
// partial product has its low TRUNC result columns forced to zero before it is
// added. With EARLY_EXIT set, a run ends as soon as the remaining multiplier
// bits are all zero.
//
// Parameters:
//   WIDTH      operand width in bits (2..32); the product is 2*WIDTH bits
//   TRUNC      low result columns masked in approximate mode (0..2*WIDTH-1)
//   EARLY_EXIT 1 = stop once the remaining bits of b are zero, 0 = fixed latency
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, approx_en sampled together)
//   a, b                 unsigned multiplicand / multiplier
//   approx_en            1 = truncated (approximate) product for this operation
//   out_valid / out_ready result handshake
//   result               2*WIDTH-bit product, held while out_valid is high
//   cycles               number of RUN cycles used for this result
// ---------------------------------------------------------------------------
module seq_approx_mult #(
    parameter int WIDTH      = 8,
    parameter int TRUNC      = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       approx_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH-1:0]         result,
    output logic [$clog2(WIDTH+1)-1:0] cycles
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    // Ones in the columns that approximate mode discards.
    localparam logic [PW-1:0] LOW_ONES = PW'((65'd1 << TRUNC) - 65'd1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q,  state_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             approx_q, approx_d;
    logic [PW-1:0]    acc_q,   acc_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [PW-1:0]    result_q, result_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    logic [PW-1:0]    mask;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    acc_next;
    logic [WIDTH-1:0] b_rem;
    logic             last_bit;

    // Datapath for the current RUN step. b_rem puts the multiplier bit being
    // processed at position 0, so bit 0 chooses whether to add, and the bits
    // above it tell early exit whether any work is left.
    always_comb begin
        mask     = approx_q ? ~LOW_ONES : '1;
        partial  = ({{WIDTH{1'b0}}, a_q} << cnt_q) & mask;
        b_rem    = b_q >> cnt_q;
        acc_next = b_rem[0] ? (acc_q + partial) : acc_q;
        last_bit = (cnt_q == CW'(WIDTH - 1)) ||
                   ((EARLY_EXIT != 0) && (b_rem[WIDTH-1:1] == '0));
    end

    // Next-state and handshake logic. A new operand is accepted only from
    // IDLE, so the edge that leaves DONE cannot also accept a new operand.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        approx_d  = approx_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        cycles_d  = cycles_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    approx_d = approx_en;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    result_d = acc_next;
                    cycles_d = cnt_q + CW'(1);
                    state_d  = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset takes priority over any handshake
    // and discards a partially built product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            approx_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            approx_q <= approx_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cycles_q <= cycles_d;
        end
    end

    assign result = result_q;
    assign cycles = cycles_q;

endmodule
